// File: rtl/vram_arb_pkg.sv
// Shared defaults and types for the VRAM arbiter.
// Width defaults match the 4096 x 8 tile RAM behind the VGA path.
package vram_arb_pkg;

    localparam int unsigned AW_DEF      = 12;
    localparam int unsigned DW_DEF      = 8;
    localparam int unsigned VIEW_W_DEF  = 7;
    localparam int unsigned STALL_W_DEF = 16;

    typedef enum logic {
        PH_ACTIVE = 1'b0,
        PH_BLANK  = 1'b1
    } phase_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of display, writer, scroll and RAM-port signals around vram_arbiter.
// slave = arbiter side, master = surrounding logic (VGA, game logic, RAM).
interface vram_arbiter_if
    import vram_arb_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned VIEW_W  = VIEW_W_DEF,
    parameter int unsigned STALL_W = STALL_W_DEF
);
    logic               vblank;
    logic               disp_req;
    logic [AW-1:0]      disp_addr;
    logic [DW-1:0]      disp_rdata;
    logic               disp_rvalid;
    logic               wr_valid;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic               wr_ready;
    logic               wr_blank_only;
    logic [VIEW_W-1:0]  view_in;
    logic [VIEW_W-1:0]  view;
    logic               ram_en;
    logic               ram_we;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_wdata;
    logic [DW-1:0]      ram_rdata;
    logic               frame_start;
    logic [STALL_W-1:0] wr_stall_last;

    modport slave (
        input  vblank, disp_req, disp_addr, wr_valid, wr_addr, wr_data, wr_blank_only,
               view_in, ram_rdata,
        output disp_rdata, disp_rvalid, wr_ready, view, ram_en, ram_we, ram_addr, ram_wdata,
               frame_start, wr_stall_last
    );

    modport master (
        output vblank, disp_req, disp_addr, wr_valid, wr_addr, wr_data, wr_blank_only,
               view_in, ram_rdata,
        input  disp_rdata, disp_rvalid, wr_ready, view, ram_en, ram_we, ram_addr, ram_wdata,
               frame_start, wr_stall_last
    );

endinterface

// File: rtl/vram_rd_pipe.sv
// Read-return pipeline: issue seen on the RAM port, data captured one cycle later.
// Stage 1 waits for the synchronous RAM, stage 2 holds the returned word.
module vram_rd_pipe #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_issue,
    input  logic [DW-1:0] i_ram_rdata,
    output logic          o_rvalid,
    output logic [DW-1:0] o_rdata
);

    logic          r_v1;
    logic          r_v2;
    logic [DW-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_data <= '0;
        end else begin
            r_v1 <= i_issue;
            r_v2 <= r_v1;
            if (r_v1) begin
                r_data <= i_ram_rdata;
            end
        end
    end

    assign o_rvalid = r_v2;
    assign o_rdata  = r_data;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads always win, writer uses valid/ready.
// Define VRAM_ARB_VIEW_SHADOW_EN to update the scroll view only at frame_start.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned VIEW_W  = VIEW_W_DEF,
    parameter int unsigned STALL_W = STALL_W_DEF
) (
    input logic           clk,
    input logic           rst,
    vram_arbiter_if.slave io_bus
);

    logic               r_vblank_q;
    logic               r_vblank_prev;
    phase_e             w_phase;
    logic               w_frame_start;
    logic               w_grant_disp;
    logic               w_wr_ready;
    logic               w_wr_fire;
    logic               w_stall;

    logic               r_ram_en;
    logic               r_ram_we;
    logic [AW-1:0]      r_ram_addr;
    logic [DW-1:0]      r_ram_wdata;

    logic [STALL_W-1:0] r_stall_cnt;
    logic [STALL_W-1:0] r_stall_last;
    logic [VIEW_W-1:0]  r_view;

    logic               w_rvalid;
    logic [DW-1:0]      w_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vblank_q    <= 1'b0;
            r_vblank_prev <= 1'b0;
        end else begin
            r_vblank_q    <= io_bus.vblank;
            r_vblank_prev <= r_vblank_q;
        end
    end

    assign w_phase       = r_vblank_q ? PH_BLANK : PH_ACTIVE;
    assign w_frame_start = r_vblank_q & ~r_vblank_prev;

    // Display has absolute priority; the writer may starve indefinitely.
    assign w_grant_disp = io_bus.disp_req;
    assign w_wr_ready   = io_bus.wr_valid & ~io_bus.disp_req &
                          (~io_bus.wr_blank_only | (w_phase == PH_BLANK));
    assign w_wr_fire    = io_bus.wr_valid & w_wr_ready;
    assign w_stall      = io_bus.wr_valid & ~w_wr_ready;

    // Address and write data hold when idle so the RAM pins only toggle on access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else if (w_grant_disp) begin
            r_ram_en   <= 1'b1;
            r_ram_we   <= 1'b0;
            r_ram_addr <= io_bus.disp_addr;
        end else if (w_wr_fire) begin
            r_ram_en    <= 1'b1;
            r_ram_we    <= 1'b1;
            r_ram_addr  <= io_bus.wr_addr;
            r_ram_wdata <= io_bus.wr_data;
        end else begin
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
        end
    end

    // A stall in the frame_start cycle itself is dropped by the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_stall_last <= '0;
        end else if (w_frame_start) begin
            r_stall_last <= r_stall_cnt;
            r_stall_cnt  <= '0;
        end else if (w_stall && (r_stall_cnt != {STALL_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_view <= '0;
        end else begin
`ifdef VRAM_ARB_VIEW_SHADOW_EN
            if (w_frame_start) begin
                r_view <= io_bus.view_in;
            end
`else
            r_view <= io_bus.view_in;
`endif
        end
    end

    vram_rd_pipe #(
        .DW (DW)
    ) u_rd_pipe (
        .clk         (clk),
        .rst         (rst),
        .i_issue     (r_ram_en & ~r_ram_we),
        .i_ram_rdata (io_bus.ram_rdata),
        .o_rvalid    (w_rvalid),
        .o_rdata     (w_rdata)
    );

    assign io_bus.disp_rvalid   = w_rvalid;
    assign io_bus.disp_rdata    = w_rdata;
    assign io_bus.wr_ready      = w_wr_ready;
    assign io_bus.ram_en        = r_ram_en;
    assign io_bus.ram_we        = r_ram_we;
    assign io_bus.ram_addr      = r_ram_addr;
    assign io_bus.ram_wdata     = r_ram_wdata;
    assign io_bus.frame_start   = w_frame_start;
    assign io_bus.wr_stall_last = r_stall_last;
    assign io_bus.view          = r_view;

endmodule
